// File: rtl/mig_app_pkg.sv
// Shared definitions for the MIG app-port arbiter: command codes, FSM states and default widths.
package mig_app_pkg;

    localparam int ADDR_W_DEF    = 29;
    localparam int DATA_W_DEF    = 256;
    localparam int TAG_DEPTH_DEF = 16;

    localparam logic [2:0] CMD_WRITE = 3'b000;
    localparam logic [2:0] CMD_READ  = 3'b001;

    typedef enum logic [1:0] {
        S_CALIB = 2'd0,
        S_IDLE  = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

endpackage

// File: rtl/mig_tag_fifo.sv
// In-order FIFO of 1-bit client ids for outstanding reads; DEPTH must be a power of 2.
module mig_tag_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     ui_clk,
    input  logic                     sys_rst,
    input  logic                     push,
    input  logic                     push_data,
    input  logic                     pop,
    output logic                     pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);

    logic          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign full     = (count == (PW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    // NOTE: storage is deliberately not reset; count/empty gate every read of it.
    always_ff @(posedge ui_clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge ui_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mig_app_arbiter.sv
// Round-robin sharing of the MIG 7-series app_* port between two clients, with in-order read return.
module mig_app_arbiter
    import mig_app_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int TAG_DEPTH = TAG_DEPTH_DEF
) (
    input  logic                         ui_clk,
    input  logic                         sys_rst,
    input  logic                         init_calib_complete,
    input  logic                         c0_valid,
    output logic                         c0_ready,
    input  logic                         c0_wr,
    input  logic [ADDR_W-1:0]            c0_addr,
    input  logic [DATA_W-1:0]            c0_wdata,
    output logic                         c0_rd_valid,
    input  logic                         c1_valid,
    output logic                         c1_ready,
    input  logic                         c1_wr,
    input  logic [ADDR_W-1:0]            c1_addr,
    input  logic [DATA_W-1:0]            c1_wdata,
    output logic                         c1_rd_valid,
    output logic [DATA_W-1:0]            rd_data,
    output logic                         app_en,
    output logic [2:0]                   app_cmd,
    output logic [ADDR_W-1:0]            app_addr,
    output logic                         app_wdf_wren,
    output logic                         app_wdf_end,
    output logic [DATA_W-1:0]            app_wdf_data,
    input  logic                         app_rdy,
    input  logic                         app_wdf_rdy,
    input  logic [DATA_W-1:0]            app_rd_data,
    input  logic                         app_rd_data_valid,
    output logic [$clog2(TAG_DEPTH):0]   rd_outstanding,
    output logic                         err_unexp_rd
);

    localparam logic [ADDR_W-1:0] BURST_MASK = {{(ADDR_W-3){1'b1}}, 3'b000};

    state_t              state;
    state_t              state_next;
    logic                last_grant;
    logic                cmd_wr;
    logic                cmd_client;
    logic [ADDR_W-1:0]   cmd_addr;
    logic [DATA_W-1:0]   cmd_wdata;
    logic                elig0, elig1, grant0, grant1;
    logic                handshake, issue_accept, rd_pop;
    logic                tag_full, tag_empty, tag_head;

    // A read may only be granted while the registered tag count has room.
    always_comb begin
        elig0  = c0_valid & (c0_wr | ~tag_full);
        elig1  = c1_valid & (c1_wr | ~tag_full);
        grant0 = elig0 & (~elig1 | last_grant);
        grant1 = elig1 & (~elig0 | ~last_grant);
    end

    assign handshake    = c0_ready | c1_ready;
    assign issue_accept = (state == S_ISSUE) & app_rdy & (~cmd_wr | app_wdf_rdy);
    assign rd_pop       = app_rd_data_valid & ~tag_empty;

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        state_next   = state;
        c0_ready     = 1'b0;
        c1_ready     = 1'b0;
        app_en       = 1'b0;
        app_wdf_wren = 1'b0;
        app_cmd      = CMD_WRITE;
        case (state)
            S_CALIB: if (init_calib_complete) state_next = S_IDLE;
            S_IDLE: begin
                if (!init_calib_complete) begin
                    state_next = S_CALIB;
                end else begin
                    c0_ready = grant0;
                    c1_ready = grant1;
                    if (grant0 | grant1) state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                app_en       = 1'b1;
                app_wdf_wren = cmd_wr;
                app_cmd      = cmd_wr ? CMD_WRITE : CMD_READ;
                if (issue_accept) state_next = S_IDLE;
            end
            default: state_next = S_CALIB;
        endcase
    end

    assign app_wdf_end  = app_wdf_wren;
    assign app_addr     = cmd_addr;
    assign app_wdf_data = cmd_wdata;

    // last_grant resets to client 1 so client 0 is preferred first.
    always_ff @(posedge ui_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state      <= S_CALIB;
            last_grant <= 1'b1;
            cmd_wr     <= 1'b0;
            cmd_client <= 1'b0;
            cmd_addr   <= '0;
            cmd_wdata  <= '0;
        end else begin
            state <= state_next;
            if (handshake) begin
                last_grant <= c1_ready;
                cmd_client <= c1_ready;
                cmd_wr     <= c1_ready ? c1_wr : c0_wr;
                cmd_addr   <= (c1_ready ? c1_addr : c0_addr) & BURST_MASK;
                cmd_wdata  <= c1_ready ? c1_wdata : c0_wdata;
            end
        end
    end

    always_ff @(posedge ui_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            c0_rd_valid  <= 1'b0;
            c1_rd_valid  <= 1'b0;
            rd_data      <= '0;
            err_unexp_rd <= 1'b0;
        end else begin
            c0_rd_valid <= rd_pop & ~tag_head;
            c1_rd_valid <= rd_pop & tag_head;
            if (rd_pop) rd_data <= app_rd_data;
            if (app_rd_data_valid & tag_empty) err_unexp_rd <= 1'b1;
        end
    end

    mig_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .ui_clk    (ui_clk),
        .sys_rst   (sys_rst),
        .push      (issue_accept & ~cmd_wr),
        .push_data (cmd_client),
        .pop       (app_rd_data_valid),
        .pop_data  (tag_head),
        .count     (rd_outstanding),
        .full      (tag_full),
        .empty     (tag_empty)
    );

endmodule

// File: tb/tb_mig_app_arbiter.sv
// Directed bench for mig_app_arbiter: calibration gating, write hold, round-robin, read return, tag-full, errors and reset.
module tb_mig_app_arbiter;

    localparam int ADDR_W    = 29;
    localparam int DATA_W    = 256;
    localparam int TAG_DEPTH = 16;

    logic              ui_clk;
    logic              sys_rst;
    logic              init_calib_complete;
    logic              c0_valid, c0_ready, c0_wr, c0_rd_valid;
    logic              c1_valid, c1_ready, c1_wr, c1_rd_valid;
    logic [ADDR_W-1:0] c0_addr, c1_addr;
    logic [DATA_W-1:0] c0_wdata, c1_wdata;
    logic [DATA_W-1:0] rd_data;
    logic              app_en;
    logic [2:0]        app_cmd;
    logic [ADDR_W-1:0] app_addr;
    logic              app_wdf_wren, app_wdf_end;
    logic [DATA_W-1:0] app_wdf_data;
    logic              app_rdy, app_wdf_rdy;
    logic [DATA_W-1:0] app_rd_data;
    logic              app_rd_data_valid;
    logic [4:0]        rd_outstanding;
    logic              err_unexp_rd;

    int checks = 0;
    int errors = 0;

    mig_app_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .TAG_DEPTH (TAG_DEPTH)
    ) dut (
        .ui_clk              (ui_clk),
        .sys_rst             (sys_rst),
        .init_calib_complete (init_calib_complete),
        .c0_valid            (c0_valid),
        .c0_ready            (c0_ready),
        .c0_wr               (c0_wr),
        .c0_addr             (c0_addr),
        .c0_wdata            (c0_wdata),
        .c0_rd_valid         (c0_rd_valid),
        .c1_valid            (c1_valid),
        .c1_ready            (c1_ready),
        .c1_wr               (c1_wr),
        .c1_addr             (c1_addr),
        .c1_wdata            (c1_wdata),
        .c1_rd_valid         (c1_rd_valid),
        .rd_data             (rd_data),
        .app_en              (app_en),
        .app_cmd             (app_cmd),
        .app_addr            (app_addr),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_data        (app_wdf_data),
        .app_rdy             (app_rdy),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid),
        .rd_outstanding      (rd_outstanding),
        .err_unexp_rd        (err_unexp_rd)
    );

    initial ui_clk = 1'b0;
    always #5 ui_clk = ~ui_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one command from client cl with app_rdy/app_wdf_rdy high; returns in S_IDLE just after a negedge.
    task automatic do_cmd(input logic cl, input logic wr, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] d);
        int n;
        if (cl) begin
            c1_valid = 1'b1; c1_wr = wr; c1_addr = addr; c1_wdata = d;
        end else begin
            c0_valid = 1'b1; c0_wr = wr; c0_addr = addr; c0_wdata = d;
        end
        #1;
        n = 0;
        while (!(cl ? c1_ready : c0_ready) && n < 20) begin
            @(negedge ui_clk); #1; n++;
        end
        check("grant_wait", n < 20, 1'b1);
        @(negedge ui_clk);
        c0_valid = 1'b0;
        c1_valid = 1'b0;
        #1;
        n = 0;
        while (app_en && n < 20) begin
            @(negedge ui_clk); #1; n++;
        end
    endtask

    int         en_cycles;
    int         gi;
    int         both;
    logic [3:0] gseq;

    initial begin
        sys_rst = 1'b0; init_calib_complete = 1'b0;
        c0_valid = 1'b0; c0_wr = 1'b0; c0_addr = '0; c0_wdata = '0;
        c1_valid = 1'b0; c1_wr = 1'b0; c1_addr = '0; c1_wdata = '0;
        app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data = '0; app_rd_data_valid = 1'b0;
        #1;
        check("rst_app_en", app_en, 1'b0);
        check("rst_c0_ready", c0_ready, 1'b0);
        check("rst_outstanding", rd_outstanding, 5'd0);
        check("rst_err", err_unexp_rd, 1'b0);

        // Calibration gating
        @(negedge ui_clk);
        sys_rst = 1'b1;
        c0_valid = 1'b1; c0_wr = 1'b1; c0_addr = '0; c0_wdata = 256'h55;
        repeat (2) begin
            @(negedge ui_clk); #1;
            check("calib_c0_ready", c0_ready, 1'b0);
            check("calib_app_en", app_en, 1'b0);
        end
        init_calib_complete = 1'b1;
        @(negedge ui_clk); #1;
        check("calib_ready_after", c0_ready, 1'b1);
        check("calib_en_not_yet", app_en, 1'b0);
        @(negedge ui_clk);
        c0_valid = 1'b0;
        #1;
        check("calib_app_en", app_en, 1'b1);
        check("calib_wren", app_wdf_wren, 1'b1);
        check("calib_cmd", app_cmd, 3'b000);

        // Write held while app_wdf_rdy is low for 3 cycles
        @(negedge ui_clk);
        c0_valid = 1'b1; c0_wr = 1'b1; c0_addr = 29'h0F; c0_wdata = 256'hAA;
        app_wdf_rdy = 1'b0;
        #1;
        check("wr_ready", c0_ready, 1'b1);
        en_cycles = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge ui_clk);
            c0_valid = 1'b0;
            if (i == 3) app_wdf_rdy = 1'b1;
            #1;
            if (app_en) en_cycles++;
            if (i == 0) begin
                check("wr_addr", app_addr, 29'h08);
                check("wr_data", app_wdf_data, 256'hAA);
                check("wr_end", app_wdf_end, 1'b1);
            end
            if (i == 2) check("wr_hold_wren", app_wdf_wren, 1'b1);
        end
        check("wr_en_cycles", en_cycles, 4);

        // Round robin with both clients continuously valid; c0 won last, so c1 goes first
        c0_valid = 1'b1; c0_wr = 1'b1; c0_addr = 29'h40; c0_wdata = 256'h1;
        c1_valid = 1'b1; c1_wr = 1'b1; c1_addr = 29'h80; c1_wdata = 256'h2;
        gi = 0; both = 0; gseq = '0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (c0_ready && c1_ready) both++;
            if (c0_ready || c1_ready) begin
                if (gi < 4) gseq[gi] = c1_ready;
                gi++;
            end
            @(negedge ui_clk);
        end
        c0_valid = 1'b0; c1_valid = 1'b0;
        check("rr_grant_count", gi, 4);
        check("rr_sequence", gseq, 4'b0101);
        check("rr_both_ready", both, 0);

        // In-order read return: c0 A, c0 B, c1 C
        do_cmd(1'b0, 1'b0, 29'h100, '0);
        do_cmd(1'b0, 1'b0, 29'h200, '0);
        do_cmd(1'b1, 1'b0, 29'h300, '0);
        check("rd_outstanding_3", rd_outstanding, 5'd3);
        @(negedge ui_clk);
        app_rd_data_valid = 1'b1; app_rd_data = 256'hA0A0;
        @(negedge ui_clk);
        app_rd_data = 256'hB0B0;
        #1;
        check("ret1_c0", c0_rd_valid, 1'b1);
        check("ret1_c1", c1_rd_valid, 1'b0);
        check("ret1_data", rd_data, 256'hA0A0);
        @(negedge ui_clk);
        app_rd_data = 256'hC0C0;
        #1;
        check("ret2_c0", c0_rd_valid, 1'b1);
        check("ret2_data", rd_data, 256'hB0B0);
        @(negedge ui_clk);
        app_rd_data_valid = 1'b0;
        #1;
        check("ret3_c0", c0_rd_valid, 1'b0);
        check("ret3_c1", c1_rd_valid, 1'b1);
        check("ret3_data", rd_data, 256'hC0C0);
        @(negedge ui_clk); #1;
        check("ret_idle_c1", c1_rd_valid, 1'b0);
        check("ret_outstanding_0", rd_outstanding, 5'd0);

        // Tag FIFO full blocks reads, not writes
        for (int i = 0; i < TAG_DEPTH; i++) do_cmd(1'b0, 1'b0, ADDR_W'(i * 8), '0);
        check("full_outstanding", rd_outstanding, 5'd16);
        c0_valid = 1'b1; c0_wr = 1'b0; c0_addr = 29'h500;
        c1_valid = 1'b1; c1_wr = 1'b1; c1_addr = 29'h600; c1_wdata = 256'h66;
        #1;
        check("full_c0_blocked", c0_ready, 1'b0);
        check("full_c1_write", c1_ready, 1'b1);
        @(negedge ui_clk);
        c1_valid = 1'b0;
        #1;
        check("full_wr_issue", app_cmd, 3'b000);
        @(negedge ui_clk); #1;
        check("full_c0_blocked2", c0_ready, 1'b0);
        @(negedge ui_clk); #1;
        check("full_c0_blocked3", c0_ready, 1'b0);
        app_rd_data_valid = 1'b1; app_rd_data = 256'h77;
        #1;
        check("full_pop_cycle_blocked", c0_ready, 1'b0);
        @(negedge ui_clk);
        app_rd_data_valid = 1'b0;
        #1;
        check("full_pop_rd_valid", c0_rd_valid, 1'b1);
        check("full_pop_data", rd_data, 256'h77);
        check("full_pop_count", rd_outstanding, 5'd15);
        check("full_c0_granted", c0_ready, 1'b1);
        @(negedge ui_clk);
        c0_valid = 1'b0;
        #1;
        check("full_rd_issue_en", app_en, 1'b1);
        check("full_rd_issue_cmd", app_cmd, 3'b001);
        check("full_rd_issue_addr", app_addr, 29'h500);
        @(negedge ui_clk); #1;
        check("full_again", rd_outstanding, 5'd16);

        // Drain, then an unexpected return
        app_rd_data_valid = 1'b1;
        repeat (TAG_DEPTH) @(negedge ui_clk);
        app_rd_data_valid = 1'b0;
        #1;
        check("drain_count", rd_outstanding, 5'd0);
        check("drain_no_err", err_unexp_rd, 1'b0);
        app_rd_data_valid = 1'b1; app_rd_data = 256'h99;
        @(negedge ui_clk);
        app_rd_data_valid = 1'b0;
        #1;
        check("unexp_err", err_unexp_rd, 1'b1);
        check("unexp_c0", c0_rd_valid, 1'b0);
        check("unexp_c1", c1_rd_valid, 1'b0);
        check("unexp_count", rd_outstanding, 5'd0);

        // Reset asserted while a write is held in S_ISSUE
        app_rdy = 1'b0;
        c1_valid = 1'b1; c1_wr = 1'b1; c1_addr = 29'h1234; c1_wdata = 256'hBEEF;
        #1;
        check("mid_c1_ready", c1_ready, 1'b1);
        @(negedge ui_clk);
        c1_valid = 1'b0;
        @(negedge ui_clk); #1;
        check("mid_held_en", app_en, 1'b1);
        check("mid_held_addr", app_addr, 29'h1230);
        sys_rst = 1'b0;
        #1;
        check("rst_mid_en", app_en, 1'b0);
        check("rst_mid_wren", app_wdf_wren, 1'b0);
        check("rst_mid_end", app_wdf_end, 1'b0);
        check("rst_mid_cmd", app_cmd, 3'b000);
        check("rst_mid_addr", app_addr, 29'h0);
        check("rst_mid_wdata", app_wdf_data, 256'h0);
        check("rst_mid_rd_data", rd_data, 256'h0);
        check("rst_mid_err", err_unexp_rd, 1'b0);
        check("rst_mid_ready", {c0_ready, c1_ready, c0_rd_valid, c1_rd_valid}, 4'b0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
